// File: rtl/tick_countdown_timer.sv
// Two-digit BCD countdown timer with start / pause / clear command FSM and a one-cycle done pulse.
// Define TICK_COUNTDOWN_TIMER_SEG7_EN to add active-low 7-segment outputs hex1/hex0.
module tick_countdown_timer #(
    parameter int unsigned TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic [1:0] state,
    output logic       busy,
    output logic       done
`ifdef TICK_COUNTDOWN_TIMER_SEG7_EN
    ,
    output logic [6:0] hex1,
    output logic [6:0] hex0
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    localparam logic [3:0] TENS_LIMIT = 4'(TENS_MAX);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] count_r;
    logic [7:0] count_s;
    logic       done_r;
    logic       done_s;
    logic [7:0] load_s;

    // Clamp each load digit so the count register only ever holds legal BCD.
    function automatic logic [7:0] sanitise(input logic [7:0] raw);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (raw[7:4] > TENS_LIMIT) ? TENS_LIMIT : raw[7:4];
        ones = (raw[3:0] > 4'd9)       ? 4'd9       : raw[3:0];
        return {tens, ones};
    endfunction

    // One BCD decrement with borrow; saturates at zero so the count cannot wrap.
    function automatic logic [7:0] bcd_dec(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'h00) begin
            res = 8'h00;
        end else if (val[3:0] != 4'd0) begin
            res = {val[7:4], val[3:0] - 4'd1};
        end else begin
            res = {val[7:4] - 4'd1, 4'd9};
        end
        return res;
    endfunction

    assign load_s = sanitise(load_val);

    // Next-state logic: clear > start > pause > tick, lower-priority inputs dropped.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        done_s  = 1'b0;
        if (clear) begin
            state_s = ST_IDLE;
            count_s = 8'h00;
        end else if (start) begin
            count_s = load_s;
            if (load_s == 8'h00) begin
                state_s = ST_EXPIRED;
                done_s  = 1'b1;
            end else begin
                state_s = ST_RUN;
            end
        end else if (pause) begin
            case (state_r)
                ST_RUN:    state_s = ST_PAUSED;
                ST_PAUSED: state_s = ST_RUN;
                default:   state_s = state_r;
            endcase
        end else if (tick && (state_r == ST_RUN)) begin
            // A count of 01 (or a corrupted 00) in RUN ends the countdown on this edge.
            if (count_r <= 8'h01) begin
                count_s = 8'h00;
                state_s = ST_EXPIRED;
                done_s  = 1'b1;
            end else begin
                count_s = bcd_dec(count_r);
            end
        end else begin
            state_s = state_r;
            count_s = count_r;
        end
    end

    // State, count and done registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= 8'h00;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            done_r  <= done_s;
        end
    end

    assign count = count_r;
    assign state = state_r;
    assign busy  = (state_r == ST_RUN) || (state_r == ST_PAUSED);
    assign done  = done_r;

`ifdef TICK_COUNTDOWN_TIMER_SEG7_EN
    // Active-low {g,f,e,d,c,b,a} glyphs; non-BCD codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign hex1 = seg7(count_r[7:4]);
    assign hex0 = seg7(count_r[3:0]);
`endif

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Self-checking bench for tick_countdown_timer (TENS_MAX=5): vector table, directed corner cases,
// and random commands against an integer-valued reference model.
module tb_tick_countdown_timer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] load_val;
    logic [7:0] count;
    logic [1:0] state;
    logic       busy;
    logic       done;
`ifdef TICK_COUNTDOWN_TIMER_SEG7_EN
    logic [6:0] hex1;
    logic [6:0] hex0;
`endif

    int checks;
    int errors;

    tick_countdown_timer #(.TENS_MAX(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .load_val (load_val),
        .count    (count),
        .state    (state),
        .busy     (busy),
        .done     (done)
`ifdef TICK_COUNTDOWN_TIMER_SEG7_EN
        ,
        .hex1     (hex1),
        .hex0     (hex0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count held as a plain integer 0..59, state as 0..3.
    int         m_val;
    logic [1:0] m_st;
    logic       m_done;

    function automatic void model_reset();
        m_val  = 0;
        m_st   = 2'd0;
        m_done = 1'b0;
    endfunction

    function automatic void model_edge(input logic c, input logic s, input logic p,
                                       input logic t, input logic [7:0] lv);
        int tens;
        int ones;
        m_done = 1'b0;
        if (c) begin
            m_st  = 2'd0;
            m_val = 0;
        end else if (s) begin
            tens  = (int'(lv[7:4]) > 5) ? 5 : int'(lv[7:4]);
            ones  = (int'(lv[3:0]) > 9) ? 9 : int'(lv[3:0]);
            m_val = tens * 10 + ones;
            if (m_val == 0) begin
                m_st   = 2'd3;
                m_done = 1'b1;
            end else begin
                m_st = 2'd1;
            end
        end else if (p) begin
            if (m_st == 2'd1) m_st = 2'd2;
            else if (m_st == 2'd2) m_st = 2'd1;
        end else if (t && m_st == 2'd1) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
                m_st   = 2'd3;
                m_done = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] m_bcd();
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(m_val / 10);
        o = 4'(m_val % 10);
        return {t, o};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] lut [10];
        lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d < 4'd10) ? lut[d] : 7'b1111111;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eb;
        eb = m_bcd();
        chk({tag, ".count"}, count, eb);
        chk({tag, ".state"}, {6'b0, state}, {6'b0, m_st});
        chk({tag, ".busy"},  {7'b0, busy}, {7'b0, (m_st == 2'd1 || m_st == 2'd2)});
        chk({tag, ".done"},  {7'b0, done}, {7'b0, m_done});
`ifdef TICK_COUNTDOWN_TIMER_SEG7_EN
        chk({tag, ".hex1"}, {1'b0, hex1}, {1'b0, glyph(eb[7:4])});
        chk({tag, ".hex0"}, {1'b0, hex0}, {1'b0, glyph(eb[3:0])});
`endif
    endtask

    // Drive one cycle's inputs, take the edge, advance the model.
    task automatic step(input logic c, input logic s, input logic p, input logic t,
                        input logic [7:0] lv);
        clear = c; start = s; pause = p; tick = t; load_val = lv;
        @(posedge clk);
        #1;
        model_edge(c, s, p, t, lv);
    endtask

    typedef struct {
        logic       c, s, p, t;
        logic [7:0] lv;
        logic [7:0] ecount;
        logic [1:0] est;
        logic       edone;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic c, input logic s, input logic p, input logic t,
                                input logic [7:0] lv, input logic [7:0] ec,
                                input logic [1:0] es, input logic ed);
        vec_t v;
        v.c = c; v.s = s; v.p = p; v.t = t; v.lv = lv;
        v.ecount = ec; v.est = es; v.edone = ed;
        vecs.push_back(v);
    endfunction

    initial begin
        int done_pulses;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        clear = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0; load_val = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.count", count, 8'h00);
        chk("reset.state", {6'b0, state}, 8'h00);
        chk("reset.busy",  {7'b0, busy}, 8'h00);
        chk("reset.done",  {7'b0, done}, 8'h00);
`ifdef TICK_COUNTDOWN_TIMER_SEG7_EN
        chk("reset.hex1", {1'b0, hex1}, 8'h40);
        chk("reset.hex0", {1'b0, hex0}, 8'h40);
`endif
        reset = 1'b1;

        //    c     s     p     t     load   count  state  done
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 8'h03, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'd3, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd3, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'd3, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'd3, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'hAC, 8'h59, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h59, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h59, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h59, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h58, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h10, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h09, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h05, 2'd1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 8'h09, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h08, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h7A, 8'h59, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 2'd0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].lv);
            chk($sformatf("vec%0d.count", i), count, vecs[i].ecount);
            chk($sformatf("vec%0d.state", i), {6'b0, state}, {6'b0, vecs[i].est});
            chk($sformatf("vec%0d.busy", i), {7'b0, busy},
                {7'b0, (vecs[i].est == 2'd1 || vecs[i].est == 2'd2)});
            chk($sformatf("vec%0d.done", i), {7'b0, done}, {7'b0, vecs[i].edone});
        end

        // Asynchronous reset in the middle of a run at 37.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h37);
        check_model("load37");
        #2 reset = 1'b0;
        #1;
        chk("async.count", count, 8'h00);
        chk("async.state", {6'b0, state}, 8'h00);
        chk("async.busy",  {7'b0, busy}, 8'h00);
        chk("async.done",  {7'b0, done}, 8'h00);
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;

        // Borrow across the tens digit: 59 down to 49.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hAC);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("borrow.count", count, 8'h49);
        check_model("borrow");

        // Pause coincident with tick at 20, ignored ticks, resume.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("pause.state", {6'b0, state}, 8'h02);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("paused.count", count, 8'h20);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("resume.count", count, 8'h19);
        check_model("resume");

        // Tick held high: load 10 reaches 00 after 10 edges with exactly one done.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
        done_pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            if (done) done_pulses++;
            if (i == 9) chk("b2b.count9", count, 8'h01);
        end
        chk("b2b.count10", count, 8'h00);
        chk("b2b.done10", {7'b0, done}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            if (done) done_pulses++;
        end
        chk("b2b.pulses", 8'(done_pulses), 8'h01);
        chk("b2b.state", {6'b0, state}, 8'h03);

`ifdef TICK_COUNTDOWN_TIMER_SEG7_EN
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h47);
        chk("seg.hex1", {1'b0, hex1}, {1'b0, 7'b0011001});
        chk("seg.hex0", {1'b0, hex0}, {1'b0, 7'b1111000});
`endif

        // Random command streams against the reference model.
        for (int i = 0; i < 1500; i++) begin
            logic       c, s, p, t;
            logic [7:0] lv;
            c  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 15) == 0);
            p  = ($urandom_range(0, 11) == 0);
            t  = ($urandom_range(0, 1) == 1);
            lv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 5));
            step(c, s, p, t, lv);
            check_model("rand");
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_countdown_timer.md
# tick_countdown_timer

Two-digit BCD countdown timer that consumes the single-cycle `go` tick from the programmable clock divider immediately upstream and decrements once per tick. A small command FSM handles start, pause/resume and clear strobes from the board-level push-button conditioning logic. It reports a one-cycle `done` pulse on expiry and presents the live count for the LED/7-segment display stage.

## Interface
- `TENS_MAX`, default 9: upper bound of the loaded tens digit (set 5 for a seconds display); legal range 1..9.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `tick` input 1: one-cycle count-enable from the upstream divider `go`; may be held high continuously when the divider ratio is 1.
- `start` input 1: one-cycle strobe; load `load_val` and run.
- `pause` input 1: one-cycle strobe; toggles RUN/PAUSED.
- `clear` input 1: one-cycle strobe; abort to IDLE.
- `load_val` input 8: BCD load value, [7:4] tens, [3:0] ones.
- `count` output 8: current BCD count, [7:4] tens, [3:0] ones, registered.
- `state` output 2: FSM state encoding.
- `busy` output 1: high in RUN or PAUSED.
- `done` output 1: registered one-cycle expiry pulse.

## Operation
- States: IDLE=2'b00, RUN=2'b01, PAUSED=2'b10, EXPIRED=2'b11.
- Command priority within one cycle: `clear` > `start` > `pause` > `tick`. Lower-priority inputs in the same cycle are discarded, not deferred.
- Load sanitising:
  - Tens digit above `TENS_MAX` loads as `TENS_MAX`.
  - Ones digit above 9 loads as 9.
  - Example with `TENS_MAX`=5: `load_val`=8'hAC loads 8'h59.
- `clear`, from any state: go to IDLE, `count`=8'h00.
- `start`, from any state:
  - Load the sanitised value.
  - Go to RUN, or to EXPIRED with `done`=1 if the sanitised value is 8'h00.
  - In RUN or PAUSED this is a restart.
- `pause`:
  - RUN goes to PAUSED; PAUSED goes to RUN.
  - Ignored in IDLE and EXPIRED.
- `tick`, in RUN only:
  - ones≠0: ones-1.
  - ones=0: ones=9, tens-1.
  - If `count` was 8'h01, `count` becomes 8'h00, the state goes to EXPIRED and `done`=1 on the same edge.
- Ticks in IDLE, PAUSED and EXPIRED are ignored.
- EXPIRED holds `count`=8'h00 until `start` or `clear`.
- `count` is never outside valid BCD and never wraps below 8'h00.
- `busy` is decoded from the registered `state`, so it carries no extra latency.

## Timing
- Reset values, asynchronous on `reset`=0: `state`=IDLE, `count`=8'h00, `busy`=0, `done`=0. Any operation in progress is abandoned immediately.
- All inputs are sampled on the rising `clk` edge.
- Outputs reflect a sampled command or tick after exactly one edge; there is no combinational input-to-output path.
- `done` is high for exactly the one cycle following the transition into EXPIRED, then low.
- Continuous `tick`=1 in RUN decrements every cycle. A load of 8'h10 reaches 8'h00 after 10 edges, with `done` on the 10th.
- A `pause` sampled together with `tick` wins, and that tick is lost.
- A `start` sampled together with the final tick wins: the timer reloads and `done` is not pulsed.

## Configuration
- `TICK_COUNTDOWN_TIMER_SEG7_EN` defined:
  - Adds outputs `hex1` (7 bits, tens) and `hex0` (7 bits, ones).
  - Bit order {g,f,e,d,c,b,a}, active-low segments, for direct drive of board 7-segment displays.
  - Decoded combinationally from registered `count`.
  - Reset value is the "0" glyph 7'b1000000 on both.
- Not defined: `hex1`/`hex0` ports and the decode logic are absent; all other behaviour is identical.

## Test plan
- Reset and expiry: assert `reset`=0 mid-RUN at count 8'h37 -> `count`=8'h00, `state`=IDLE, `busy`=0, `done`=0 asynchronously. Release, `start` with 8'h03, then 3 ticks -> `count` 02, 01, 00, with `done` high for one cycle after the third tick and `state`=EXPIRED.
- Borrow and clamp: `TENS_MAX`=5, `start` with 8'hAC -> `count`=8'h59. Count down to 8'h50, one tick -> 8'h49. `start` with 8'h00 -> EXPIRED, `done` pulsed, no RUN cycle.
- Pause/resume: in RUN at 8'h20, `pause` coincident with `tick` -> PAUSED, `count` stays 8'h20. Five ticks -> still 8'h20. `pause` -> RUN, next tick -> 8'h19.
- Priority: at 8'h01 in RUN, `start`(8'h05) coincident with `tick` -> `count`=8'h05, RUN, `done`=0. `clear`+`start` together -> IDLE, 8'h00.
- Back-to-back ticks: `tick` held high, load 8'h10 -> 8'h00 after exactly 10 cycles, one `done` pulse. Ticks afterwards leave the state in EXPIRED.
- With `TICK_COUNTDOWN_TIMER_SEG7_EN`: count 8'h47 -> `hex1`=7'b0011001, `hex0`=7'b1111000. After reset both = 7'b1000000.
